// File: rtl/lighthouse_scheduler.sv
// Round-robin pulse-width scheduler: one high/low measurement engine shared across lighthouse sensor inputs.
// Optional result interrupt when LIGHTHOUSE_SCHED_IRQ_EN is defined; otherwise irq is tied low.
module lighthouse_scheduler #(
  parameter int unsigned NUM_SENSORS = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_RST = 100000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2:0]             address,
  input  logic                   write,
  input  logic [31:0]            writedata,
  input  logic                   read,
  output logic [31:0]            readdata,
  output logic                   waitrequest,
  input  logic [NUM_SENSORS-1:0] sensor_signal_i,
  output logic                   irq
);

  localparam int unsigned IDX_W     = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam logic [31:0] BLOCK_ID  = 32'h0000_0006;
  localparam logic [31:0] BAD_READ  = 32'hDEAD_BEEF;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SELECT    = 4'd1,
    S_WAIT_RISE = 4'd2,
    S_MEAS_HIGH = 4'd3,
    S_MEAS_LOW  = 4'd4,
    S_STORE     = 4'd5
  } state_t;

  state_t                 state, state_d;
  logic [3:0]             cur_ch, cur_ch_d;
  logic [IDX_W-1:0]       cur_idx;

  logic [NUM_SENSORS-1:0] sync1, sync2, sync3;
  logic                   sig, sig_prev;

  logic [NUM_SENSORS-1:0] mask, mask_d;
  logic [NUM_SENSORS-1:0] valid, valid_d;
  logic [NUM_SENSORS-1:0] tmo_flags, tmo_d;
  logic [NUM_SENSORS-1:0] cur_onehot;
  logic [CNT_W-1:0]       timeout;
  logic [31:0]            sel;
  logic                   sel_ok;
  logic [IDX_W-1:0]       sel_idx;

  logic [CNT_W-1:0]       cnt_h, cnt_l, tcnt;
  logic [CNT_W-1:0]       res_h [NUM_SENSORS];
  logic [CNT_W-1:0]       res_l [NUM_SENSORS];

  logic                   clr_cnt, start_h, inc_h, start_l, inc_l, run_tmo;
  logic                   do_store, do_tmo, tmo_hit;
  logic                   next_found;
  logic [IDX_W-1:0]       next_idx;
  logic [31:0]            scan_idx;
  logic                   unused_read;

  assign unused_read = read;
  assign waitrequest = 1'b0;
  assign cur_idx     = IDX_W'(cur_ch);
  assign sig         = sync2[cur_idx];
  assign sig_prev    = sync3[cur_idx];
  assign cur_onehot  = NUM_SENSORS'(1) << cur_idx;
  assign tmo_hit     = (timeout != '0) && (tcnt >= timeout - CNT_W'(1));
  assign sel_ok      = sel < 32'(NUM_SENSORS);
  assign sel_idx     = IDX_W'(sel);

  // First enabled channel strictly after cur_ch, wrapping back to cur_ch itself last.
  always_comb begin
    next_found = 1'b0;
    next_idx   = cur_idx;
    scan_idx   = '0;
    for (int unsigned i = 1; i <= NUM_SENSORS; i++) begin
      scan_idx = (32'(cur_ch) + i) % NUM_SENSORS;
      if (!next_found && mask[IDX_W'(scan_idx)]) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(scan_idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cur_ch <= 4'd0;
    end else begin
      state  <= state_d;
      cur_ch <= cur_ch_d;
    end
  end

  always_comb begin
    state_d  = state;
    cur_ch_d = cur_ch;
    clr_cnt  = 1'b0;
    start_h  = 1'b0;
    inc_h    = 1'b0;
    start_l  = 1'b0;
    inc_l    = 1'b0;
    run_tmo  = 1'b0;
    do_store = 1'b0;
    do_tmo   = 1'b0;
    case (state)
      S_IDLE: begin
        if (|mask) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (next_found) begin
          cur_ch_d = 4'(next_idx);
          clr_cnt  = 1'b1;
          state_d  = S_WAIT_RISE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RISE, S_MEAS_HIGH, S_MEAS_LOW: begin
        // Timeout takes priority over any edge seen in the same cycle.
        if (tmo_hit) begin
          do_tmo  = 1'b1;
          state_d = S_SELECT;
        end else begin
          run_tmo = 1'b1;
          case (state)
            S_WAIT_RISE: begin
              if (sig && !sig_prev) begin
                start_h = 1'b1;
                state_d = S_MEAS_HIGH;
              end
            end
            S_MEAS_HIGH: begin
              if (!sig) begin
                start_l = 1'b1;
                state_d = S_MEAS_LOW;
              end else begin
                inc_h = 1'b1;
              end
            end
            default: begin
              if (sig) state_d = S_STORE;
              else     inc_l   = 1'b1;
            end
          endcase
        end
      end
      S_STORE: begin
        do_store = 1'b1;
        state_d  = S_SELECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flag updates: a hardware set in the same cycle as a W1C wins.
  always_comb begin
    mask_d  = (write && address == 3'd0) ? writedata[NUM_SENSORS-1:0] : mask;
    valid_d = valid;
    tmo_d   = tmo_flags;
    if (write && address == 3'd1) valid_d = valid_d & ~writedata[NUM_SENSORS-1:0];
    if (write && address == 3'd2) tmo_d   = tmo_d & ~writedata[NUM_SENSORS-1:0];
    if (do_store) valid_d = valid_d | cur_onehot;
    if (do_tmo)   tmo_d   = tmo_d | cur_onehot;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sync3     <= '0;
      mask      <= '0;
      valid     <= '0;
      tmo_flags <= '0;
      timeout   <= CNT_W'(TIMEOUT_RST);
      sel       <= '0;
      cnt_h     <= '0;
      cnt_l     <= '0;
      tcnt      <= '0;
      for (int i = 0; i < int'(NUM_SENSORS); i++) begin
        res_h[i] <= '0;
        res_l[i] <= '0;
      end
    end else begin
      sync1     <= sensor_signal_i;
      sync2     <= sync1;
      sync3     <= sync2;
      mask      <= mask_d;
      valid     <= valid_d;
      tmo_flags <= tmo_d;
      if (write && address == 3'd3) timeout <= CNT_W'(writedata);
      if (write && address == 3'd4) sel     <= writedata;

      if (clr_cnt) begin
        cnt_h <= '0;
        cnt_l <= '0;
        tcnt  <= '0;
      end else begin
        if (run_tmo && tcnt != CNT_MAX)  tcnt  <= tcnt + CNT_W'(1);
        if (start_h)                     cnt_h <= CNT_W'(1);
        else if (inc_h && cnt_h != CNT_MAX) cnt_h <= cnt_h + CNT_W'(1);
        if (start_l)                     cnt_l <= CNT_W'(1);
        else if (inc_l && cnt_l != CNT_MAX) cnt_l <= cnt_l + CNT_W'(1);
      end

      if (do_store) begin
        res_h[cur_idx] <= cnt_h;
        res_l[cur_idx] <= cnt_l;
      end
    end
  end

  always_comb begin
    readdata = BAD_READ;
    case (address)
      3'd0: readdata = BLOCK_ID;
      3'd1: readdata = 32'(valid);
      3'd2: readdata = 32'(tmo_flags);
      3'd3: readdata = 32'(timeout);
      3'd4: readdata = sel;
      3'd5: if (sel_ok) readdata = 32'(res_h[sel_idx]);
      3'd6: if (sel_ok) readdata = 32'(res_l[sel_idx]);
      3'd7: readdata = {24'b0, state, cur_ch};
      default: readdata = BAD_READ;
    endcase
  end

`ifdef LIGHTHOUSE_SCHED_IRQ_EN
  // Built from next-cycle flag/mask values so irq rises the cycle after STORE.
  logic irq_q;
  always_ff @(posedge clock) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |(valid_d & mask_d);
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_lighthouse_scheduler.sv
// Directed bench for lighthouse_scheduler: register map, measurement, round-robin, timeout, flag races, reset.
module tb_lighthouse_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [15:0] sensor_signal_i;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int visits[$];
  logic exp_irq;

  lighthouse_scheduler dut (
    .clock(clock), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .sensor_signal_i(sensor_signal_i), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    #1;
    d = readdata;
    read = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; write = 1'b0; read = 1'b0; address = 3'd0;
    writedata = '0; sensor_signal_i = '0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic drive_wave(input int ch, input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      sensor_signal_i[4'(ch)] = 1'b1;
      repeat (h) tick();
      sensor_signal_i[4'(ch)] = 1'b0;
      repeat (l) tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    rd(3'd0, d); checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL reset_id: got %h expected %h", d, 32'h6); end
    rd(3'd3, d); checks++;
    if (d !== 32'd100000) begin errors++; $display("FAIL reset_timeout: got %h expected %h", d, 32'd100000); end
    rd(3'd7, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h0); end
    rd(3'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_valid: got %h expected %h", d, 32'h0); end
    rd(3'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_tmo: got %h expected %h", d, 32'h0); end
    rd(3'd4, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_sel: got %h expected %h", d, 32'h0); end
    checks++;
    if (waitrequest !== 1'b0) begin errors++; $display("FAIL waitrequest: got %b expected 0", waitrequest); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_single_channel();
    logic [31:0] d;
    do_reset();
    wr(3'd0, 32'h2);
    repeat (10) tick();
    sensor_signal_i[1] = 1'b1; repeat (10) tick();
    sensor_signal_i[1] = 1'b0; repeat (20) tick();
    sensor_signal_i[1] = 1'b1; repeat (8) tick();
    wr(3'd4, 32'd1);
    rd(3'd4, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL single_sel: got %h expected %h", d, 32'd1); end
    rd(3'd5, d); checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL single_high: got %0d expected 10", d); end
    rd(3'd6, d); checks++;
    if (d !== 32'd20) begin errors++; $display("FAIL single_low: got %0d expected 20", d); end
    rd(3'd1, d); checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL single_valid: got %h expected %h", d, 32'h2); end
    rd(3'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL single_tmo: got %h expected %h", d, 32'h0); end
    checks++;
    if (waitrequest !== 1'b0) begin errors++; $display("FAIL single_waitreq: got %b expected 0", waitrequest); end
  endtask

  task automatic test_round_robin();
    logic [31:0] d;
    logic [3:0]  last;
    do_reset();
    visits.delete();
    wr(3'd0, 32'h9);
    last = 4'hF;
    fork
      drive_wave(0, 5, 7, 17);
      drive_wave(3, 8, 12, 10);
      begin
        for (int i = 0; i < 205; i++) begin
          @(posedge clock); #2;
          address = 3'd7; #1;
          if (readdata[3:0] !== last) begin
            last = readdata[3:0];
            visits.push_back(int'(last));
          end
        end
      end
    join
    checks++;
    if (visits.size() < 4) begin
      errors++; $display("FAIL rr_visit_count: got %0d expected >= 4", visits.size());
    end else begin
      checks++;
      if (visits[0] != 0 || visits[1] != 3 || visits[2] != 0 || visits[3] != 3) begin
        errors++;
        $display("FAIL rr_order: got %0d,%0d,%0d,%0d expected 0,3,0,3", visits[0], visits[1], visits[2], visits[3]);
      end
    end
    rd(3'd1, d); checks++;
    if (d !== 32'h9) begin errors++; $display("FAIL rr_valid: got %h expected %h", d, 32'h9); end
    wr(3'd4, 32'd0);
    rd(3'd5, d); checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL rr_ch0_high: got %0d expected 5", d); end
    rd(3'd6, d); checks++;
    if (d !== 32'd7) begin errors++; $display("FAIL rr_ch0_low: got %0d expected 7", d); end
    wr(3'd4, 32'd3);
    rd(3'd5, d); checks++;
    if (d !== 32'd8) begin errors++; $display("FAIL rr_ch3_high: got %0d expected 8", d); end
    rd(3'd6, d); checks++;
    if (d !== 32'd12) begin errors++; $display("FAIL rr_ch3_low: got %0d expected 12", d); end
    wr(3'd4, 32'd16);
    rd(3'd5, d); checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sel_range_high: got %h expected %h", d, 32'hDEAD_BEEF); end
    rd(3'd6, d); checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sel_range_low: got %h expected %h", d, 32'hDEAD_BEEF); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    do_reset();
    wr(3'd3, 32'd100);
    wr(3'd0, 32'h4);
    repeat (60) tick();
    rd(3'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL tmo_early: got %h expected %h", d, 32'h0); end
    repeat (70) tick();
    rd(3'd2, d); checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL tmo_flag: got %h expected %h", d, 32'h4); end
    rd(3'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL tmo_valid: got %h expected %h", d, 32'h0); end
    rd(3'd7, d); checks++;
    if (d !== 32'h22) begin errors++; $display("FAIL tmo_revisit: got %h expected %h", d, 32'h22); end
    wr(3'd2, 32'h4);
    rd(3'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL tmo_w1c: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    logic        found;
`ifdef LIGHTHOUSE_SCHED_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    do_reset();
    wr(3'd0, 32'h2);
    wr(3'd4, 32'd1);
    repeat (10) tick();
    sensor_signal_i[1] = 1'b1; repeat (6) tick();
    sensor_signal_i[1] = 1'b0; repeat (9) tick();
    sensor_signal_i[1] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      address = 3'd7; #1;
      if (readdata[7:4] == 4'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL race_store_seen: got no STORE expected STORE within 20 cycles");
    end else begin
      rd(3'd5, d); checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL race_prestore_read: got %0d expected 0", d); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL race_irq_store: got %b expected 0", irq); end
      wr(3'd1, 32'h2);
      checks++;
      if (irq !== exp_irq) begin errors++; $display("FAIL race_irq_rise: got %b expected %b", irq, exp_irq); end
      rd(3'd1, d); checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL race_set_wins: got %h expected %h", d, 32'h2); end
      rd(3'd5, d); checks++;
      if (d !== 32'd6) begin errors++; $display("FAIL race_high: got %0d expected 6", d); end
      rd(3'd6, d); checks++;
      if (d !== 32'd9) begin errors++; $display("FAIL race_low: got %0d expected 9", d); end
      wr(3'd1, 32'h2);
      rd(3'd1, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL race_w1c: got %h expected %h", d, 32'h0); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL race_irq_fall: got %b expected 0", irq); end
    end
  endtask

  task automatic test_reset_mid_measure();
    logic [31:0] d;
    logic        found;
    do_reset();
    wr(3'd3, 32'd500);
    wr(3'd0, 32'h2);
    wr(3'd4, 32'd1);
    repeat (10) tick();
    sensor_signal_i[1] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      address = 3'd7; #1;
      if (readdata[7:4] == 4'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_meas_seen: got no MEAS_HIGH expected MEAS_HIGH"); end
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sensor_signal_i = '0;
    rd(3'd7, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_status: got %h expected %h", d, 32'h0); end
    rd(3'd3, d); checks++;
    if (d !== 32'd100000) begin errors++; $display("FAIL mid_timeout: got %0d expected 100000", d); end
    rd(3'd4, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_sel: got %h expected %h", d, 32'h0); end
    rd(3'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_valid: got %h expected %h", d, 32'h0); end
    repeat (5) tick();
    rd(3'd7, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_idle_stays: got %h expected %h", d, 32'h0); end
    wr(3'd4, 32'd1);
    rd(3'd5, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_result_cleared: got %h expected %h", d, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b expected 0", irq); end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_timeout();
    test_w1c_race();
    test_reset_mid_measure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
